// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM access arbiter: FSM states, grant codes and
// the longword address width of both requester ports.
package sdram_pkg;

   localparam int ADDR_W = 26;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GNT0    = 2'd1,
      ST_GNT1    = 2'd2,
      ST_REFRESH = 2'd3
   } arb_state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_P0   = 2'b01;
   localparam logic [1:0] GNT_P1   = 2'b10;
   localparam logic [1:0] GNT_REF  = 2'b11;

   function automatic logic [1:0] grant_code(input arb_state_e s);
      case (s)
         ST_GNT0:    return GNT_P0;
         ST_GNT1:    return GNT_P1;
         ST_REFRESH: return GNT_REF;
         default:    return GNT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sdram_arb_starve_ctr.sv
// Saturating wait counter for port 1; flags starvation once MAX_WAIT
// consecutive pending cycles have been seen.
module sdram_arb_starve_ctr #(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 8
) (
   input  logic CLK,
   input  logic RESET_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic starved_o
);

   localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q < MAX_C))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign starved_o = (cnt_q >= MAX_C);

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller port between the Zorro III slave path (port 0),
// the DMA/cache-fill engine (port 1) and refresh. SDRAM_ARB_RR_EN swaps the
// fixed-priority/starvation-guard scheme for port round-robin.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 8
) (
   input  logic              CLK,
   input  logic              RESET_n,
   input  logic              refresh_req,
   input  logic              refresh_done,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic              rw0,
   input  logic [3:0]        ds0_n,
   output logic              ack0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              rw1,
   input  logic [3:0]        ds1_n,
   output logic              ack1,
   output logic              ctl_req,
   output logic [ADDR_W-1:0] ctl_addr,
   output logic              ctl_rw,
   output logic [3:0]        ctl_ds_n,
   input  logic              ctl_ack,
   output logic              ctl_refresh,
   output logic [1:0]        grant
);

   arb_state_e        state_q, state_d;
   logic              abort_q, abort_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rw_q, rw_d;
   logic              enter0, enter1;
   logic              pick1;

   assign enter0 = (state_q == ST_IDLE) && (state_d == ST_GNT0);
   assign enter1 = (state_q == ST_IDLE) && (state_d == ST_GNT1);

`ifdef SDRAM_ARB_RR_EN
   // last1_q set: port 1 owned the most recent grant, so port 0 wins a tie
   logic last1_q, last1_d;

   assign pick1 = req1 && (!req0 || !last1_q);

   always_comb begin
      last1_d = last1_q;
      if (enter0)      last1_d = 1'b0;
      else if (enter1) last1_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) last1_q <= 1'b1;
      else          last1_q <= last1_d;
   end
`else
   logic starved;

   sdram_arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
   ) u_starve (
      .CLK       (CLK),
      .RESET_n   (RESET_n),
      .inc_i     (req1 && (state_q != ST_GNT1)),
      .clr_i     (!req1 || enter1),
      .starved_o (starved)
   );

   assign pick1 = req1 && (starved || !req0);
`endif

   // state register
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // next state: arbitration happens in IDLE only, grants never preempted
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (refresh_req) state_d = ST_REFRESH;
            else if (pick1)  state_d = ST_GNT1;
            else if (req0)   state_d = ST_GNT0;
         end
         ST_GNT0, ST_GNT1: if (ctl_ack) state_d = ST_IDLE;
         ST_REFRESH:       if (refresh_done) state_d = ST_IDLE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // A requester that withdraws mid-grant loses its ack; the controller
   // cycle still runs to completion.
   always_comb begin
      abort_d = abort_q;
      if (enter0 || enter1)
         abort_d = 1'b0;
      else if (((state_q == ST_GNT0) && !req0) || ((state_q == ST_GNT1) && !req1))
         abort_d = 1'b1;
   end

   always_comb begin
      addr_d = addr_q;
      rw_d   = rw_q;
      if (enter0) begin
         addr_d = addr0;
         rw_d   = rw0;
      end else if (enter1) begin
         addr_d = addr1;
         rw_d   = rw1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         abort_q <= 1'b0;
         addr_q  <= '0;
         rw_q    <= 1'b1;
      end else begin
         abort_q <= abort_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
      end
   end

   // outputs; strobes bypass the register since Zorro III drives them late
   always_comb begin
      ctl_req     = (state_q == ST_GNT0) || (state_q == ST_GNT1);
      ctl_refresh = (state_q == ST_REFRESH);
      grant       = grant_code(state_q);
      ctl_addr    = addr_q;
      ctl_rw      = rw_q;
      ack0        = ctl_ack && (state_q == ST_GNT0) && req0 && !abort_q;
      ack1        = ctl_ack && (state_q == ST_GNT1) && req1 && !abort_q;
      ctl_ds_n    = 4'b1111;
      if (state_q == ST_GNT0)      ctl_ds_n = ds0_n;
      else if (state_q == ST_GNT1) ctl_ds_n = ds1_n;
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter (MAX_WAIT = 4); build with
// SDRAM_ARB_RR_EN to exercise the round-robin variant instead.
module tb_sdram_arbiter;
   import sdram_pkg::*;

   logic        CLK = 1'b0, RESET_n = 1'b0;
   logic        refresh_req = 1'b0, refresh_done = 1'b0, ctl_ack = 1'b0;
   logic        req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
   logic [25:0] addr0 = '0, addr1 = '0;
   logic [3:0]  ds0_n = 4'hF, ds1_n = 4'hF;
   logic        ack0, ack1, ctl_req, ctl_rw, ctl_refresh;
   logic [25:0] ctl_addr;
   logic [3:0]  ctl_ds_n;
   logic [1:0]  grant;

   typedef struct {
      logic [1:0]  g;
      logic [25:0] a;
      logic        rw;
   } exp_t;

   exp_t       gq[$];
   logic [1:0] aq[$];
   logic [1:0] prev_g = 2'b00;
   int         errors = 0, checks = 0;

   sdram_arbiter #(.MAX_WAIT(4), .WAIT_W(8)) dut (
      .CLK(CLK), .RESET_n(RESET_n),
      .refresh_req(refresh_req), .refresh_done(refresh_done),
      .req0(req0), .addr0(addr0), .rw0(rw0), .ds0_n(ds0_n), .ack0(ack0),
      .req1(req1), .addr1(addr1), .rw1(rw1), .ds1_n(ds1_n), .ack1(ack1),
      .ctl_req(ctl_req), .ctl_addr(ctl_addr), .ctl_rw(ctl_rw), .ctl_ds_n(ctl_ds_n),
      .ctl_ack(ctl_ack), .ctl_refresh(ctl_refresh), .grant(grant)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_g(input logic [1:0] g, input logic [25:0] a, input logic rw);
      gq.push_back('{g, a, rw});
   endtask

   task automatic wait_req(input int bound);
      int n;
      n = 0;
      while (!ctl_req && n < bound) begin
         tick();
         n++;
      end
      chk("grant_wait", 32'(ctl_req), 32'd1);
   endtask

   task automatic serve(input int lat, input bit d0, input bit d1);
      chk("req_held", 32'(ctl_req), 32'd1);
      repeat (lat) tick();
      ctl_ack = 1'b1;
      tick();
      ctl_ack = 1'b0;
      if (d0) req0 = 1'b0;
      if (d1) req1 = 1'b0;
   endtask

   task automatic do_reset();
      RESET_n = 1'b0;
      tick();
      RESET_n = 1'b1;
      tick();
   endtask

   // monitor: every new grant and every ack is matched against the queues
   always @(negedge CLK) begin
      if (grant != GNT_NONE && prev_g == GNT_NONE) begin
         if (gq.size() == 0) begin
            chk("grant_unexpected", 32'(grant), 32'(GNT_NONE));
         end else begin
            chk("sb_grant", 32'(grant), 32'(gq[0].g));
            if (gq[0].g != GNT_REF) begin
               chk("sb_addr", 32'(ctl_addr), 32'(gq[0].a));
               chk("sb_rw", 32'(ctl_rw), 32'(gq[0].rw));
            end
            gq.delete(0);
         end
      end
      if (ack0 || ack1) begin
         if (aq.size() == 0) begin
            chk("ack_unexpected", 32'({ack1, ack0}), 32'd0);
         end else begin
            chk("sb_ack", 32'({ack1, ack0}), 32'(aq[0]));
            aq.delete(0);
         end
      end
      prev_g <= grant;
   end

   initial begin
      // reset values
      #12;
      chk("rst_ctl_req", 32'(ctl_req), 32'd0);
      chk("rst_ctl_refresh", 32'(ctl_refresh), 32'd0);
      chk("rst_ack", 32'({ack1, ack0}), 32'd0);
      chk("rst_grant", 32'(grant), 32'(GNT_NONE));
      chk("rst_addr", 32'(ctl_addr), 32'd0);
      chk("rst_rw", 32'(ctl_rw), 32'd1);
      chk("rst_ds_n", 32'(ctl_ds_n), 32'hF);
      tick();
      RESET_n = 1'b1;
      tick();

      // single port 0 read, ack three cycles after ctl_req
      push_g(GNT_P0, 26'h0000123, 1'b1);
      aq.push_back(2'b01);
      req0 = 1'b1; addr0 = 26'h0000123; rw0 = 1'b1; ds0_n = 4'b0000;
      #1 chk("t1_no_early_req", 32'(ctl_req), 32'd0);
      tick();
      chk("t1_req_latency", 32'(ctl_req), 32'd1);
      ds0_n = 4'b1010;
      #1 chk("t1_ds_comb", 32'(ctl_ds_n), 32'hA);
      serve(3, 1'b1, 1'b0);
      chk("t1_req_drop", 32'(ctl_req), 32'd0);
      tick(); tick();

      // abort: req0 withdrawn a cycle into the grant
      push_g(GNT_P0, 26'h2AAAAAA, 1'b0);
      req0 = 1'b1; addr0 = 26'h2AAAAAA; rw0 = 1'b0;
      tick();
      tick();
      req0 = 1'b0;
      tick();
      ctl_ack = 1'b1;
      #1 chk("t4_ack0_suppressed", 32'(ack0), 32'd0);
      chk("t4_req_held", 32'(ctl_req), 32'd1);
      tick();
      ctl_ack = 1'b0;
      chk("t4_back_idle", 32'(grant), 32'(GNT_NONE));

      // spurious ctl_ack / refresh_done in IDLE
      ctl_ack = 1'b1; refresh_done = 1'b1;
      tick();
      ctl_ack = 1'b0; refresh_done = 1'b0;
      chk("spurious_idle", 32'(grant), 32'(GNT_NONE));
      tick();

`ifndef SDRAM_ARB_RR_EN
      // refresh beats both ports, then port 0, then port 1
      push_g(GNT_REF, 26'h0, 1'b0);
      push_g(GNT_P0, 26'h00000A0, 1'b1);
      push_g(GNT_P1, 26'h00000B0, 1'b0);
      push_g(GNT_REF, 26'h0, 1'b0);
      aq.push_back(2'b01);
      aq.push_back(2'b10);
      refresh_req = 1'b1;
      req0 = 1'b1; addr0 = 26'h00000A0; rw0 = 1'b1;
      req1 = 1'b1; addr1 = 26'h00000B0; rw1 = 1'b0;
      tick();
      chk("t2_refresh", 32'(ctl_refresh), 32'd1);
      chk("t2_no_ctl_req", 32'(ctl_req), 32'd0);
      refresh_done = 1'b1; refresh_req = 1'b0;
      tick();
      refresh_done = 1'b0;
      chk("t2_refresh_done", 32'(ctl_refresh), 32'd0);
      wait_req(5);
      serve(1, 1'b1, 1'b0);
      wait_req(5);
      // refresh raised mid-grant, then coincident with ctl_ack
      refresh_req = 1'b1;
      tick();
      chk("t2_no_preempt", 32'(grant), 32'(GNT_P1));
      serve(0, 1'b0, 1'b1);
      chk("t2_idle_bubble", 32'(grant), 32'(GNT_NONE));
      tick();
      chk("t2_refresh_after", 32'(ctl_refresh), 32'd1);
      refresh_done = 1'b1; refresh_req = 1'b0;
      tick();
      refresh_done = 1'b0;
      tick();

      // starvation guard: port 1 wins once it has waited 4 cycles
      push_g(GNT_P0, 26'h0000300, 1'b1);
      push_g(GNT_P0, 26'h0000301, 1'b1);
      push_g(GNT_P1, 26'h0000310, 1'b1);
      push_g(GNT_P0, 26'h0000301, 1'b1);
      aq.push_back(2'b01);
      aq.push_back(2'b01);
      aq.push_back(2'b10);
      aq.push_back(2'b01);
      req0 = 1'b1; addr0 = 26'h0000300; rw0 = 1'b1;
      req1 = 1'b1; addr1 = 26'h0000310; rw1 = 1'b1;
      wait_req(5);
      serve(1, 1'b0, 1'b0);
      addr0 = 26'h0000301;
      wait_req(5);
      serve(1, 1'b0, 1'b0);
      wait_req(5);
      chk("t3_starve_grant", 32'(grant), 32'(GNT_P1));
      serve(1, 1'b0, 1'b1);
      wait_req(5);
      serve(1, 1'b1, 1'b0);
      tick();
`else
      // round-robin alternation with both ports held
      do_reset();
      push_g(GNT_P0, 26'h0000400, 1'b1);
      push_g(GNT_P1, 26'h0000410, 1'b0);
      push_g(GNT_P0, 26'h0000400, 1'b1);
      push_g(GNT_P1, 26'h0000410, 1'b0);
      aq.push_back(2'b01);
      aq.push_back(2'b10);
      aq.push_back(2'b01);
      aq.push_back(2'b10);
      req0 = 1'b1; addr0 = 26'h0000400; rw0 = 1'b1;
      req1 = 1'b1; addr1 = 26'h0000410; rw1 = 1'b0;
      wait_req(5);
      serve(1, 1'b0, 1'b0);
      wait_req(5);
      serve(1, 1'b0, 1'b0);
      wait_req(5);
      serve(1, 1'b0, 1'b0);
      wait_req(5);
      serve(1, 1'b1, 1'b1);
      tick();
`endif

      // asynchronous reset while port 1 owns the controller
      push_g(GNT_P1, 26'h0000155, 1'b0);
      req1 = 1'b1; addr1 = 26'h0000155; rw1 = 1'b0;
      wait_req(5);
      @(negedge CLK);
      #2;
      ctl_ack = 1'b1;
      RESET_n = 1'b0;
      #1;
      chk("t5_grant", 32'(grant), 32'(GNT_NONE));
      chk("t5_ctl_req", 32'(ctl_req), 32'd0);
      chk("t5_addr", 32'(ctl_addr), 32'd0);
      chk("t5_rw", 32'(ctl_rw), 32'd1);
      chk("t5_ack1", 32'(ack1), 32'd0);
      chk("t5_ds_n", 32'(ctl_ds_n), 32'hF);
      ctl_ack = 1'b0;
      req1 = 1'b0;
      tick();
      RESET_n = 1'b1;
      tick(); tick();

      chk("grant_queue_drained", 32'(gq.size()), 32'd0);
      chk("ack_queue_drained", 32'(aq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller access port between two requesters.
  - Port 0: the Zorro III slave path.
  - Port 1: the local DMA/cache-fill engine.
- Also sequences refresh requests into the same port.
- Sits between the bus-interface logic and the SDRAM controller.
- Uses fixed priority: refresh first, then port 0, then port 1. A starvation guard protects port 1.

Parameters:
- MAX_WAIT, 15: cycles port 1 may wait while pending before it outranks port 0. Legal range 1..255.
- WAIT_W, 8: width of the starvation counter. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- CLK  in  1  system clock; all state on posedge.
- RESET_n  in  1  asynchronous, active-low reset.
- refresh_req  in  1  level; refresh due, from the refresh timer.
- refresh_done  in  1  one-cycle pulse from the controller; refresh sequence finished.
- req0  in  1  port 0 request; held until ack0.
- addr0  in  26  port 0 longword address [27:2].
- rw0  in  1  port 0 direction; 1 = read.
- ds0_n  in  4  port 0 byte strobes, active low.
- ack0  out  1  port 0 access complete.
- req1, addr1, rw1, ds1_n, ack1: same as port 0, for port 1.
- ctl_req  out  1  access request to the controller.
- ctl_addr  out  26  latched address of the granted port.
- ctl_rw  out  1  latched direction of the granted port.
- ctl_ds_n  out  4  byte strobes of the granted port.
- ctl_ack  in  1  one-cycle pulse; controller finished the access.
- ctl_refresh  out  1  refresh request to the controller.
- grant  out  2  current owner: 00 none, 01 port 0, 10 port 1, 11 refresh.

Behaviour:
- Reset values:
  - State = IDLE.
  - ctl_req, ctl_refresh, ack0, ack1 = 0.
  - grant = 00.
  - ctl_addr = 0, ctl_rw = 1.
  - Starvation counter = 0.
- States: IDLE, GNT0, GNT1, REFRESH. Decisions are evaluated in IDLE only.
- IDLE, priority order:
  1. refresh_req -> REFRESH.
  2. req1 with counter >= MAX_WAIT -> GNT1.
  3. req0 -> GNT0.
  4. req1 -> GNT1.
  5. Otherwise stay in IDLE.
- Grant latency:
  - On entering GNTn, ctl_addr and ctl_rw are registered from port n.
  - ctl_req rises in the same edge, so it is visible one cycle after the request is sampled in IDLE.
  - ctl_addr and ctl_rw stay stable for the whole grant.
- ctl_ds_n is combinational from the granted port's ds_n, because strobes arrive late on Zorro III. It is 4'b1111 when no port is granted.
- GNTn:
  - ctl_req is held until ctl_ack.
  - ackn = ctl_ack AND (state == GNTn), combinational, one cycle wide.
  - On ctl_ack, next state is IDLE and ctl_req drops.
  - There is always one IDLE bubble between grants.
- Abort: if reqn drops before ctl_ack, ctl_req stays asserted until ctl_ack, and ackn is suppressed. The controller cycle is never cut short.
- REFRESH: ctl_refresh = 1 until refresh_done; then IDLE.
- refresh_req arriving during GNTn waits for IDLE; it is never preemptive.
- Starvation counter:
  - Increments each cycle that req1 = 1 and state != GNT1.
  - Saturates at MAX_WAIT.
  - Clears on entry to GNT1 or when req1 = 0.
- Simultaneous events:
  - ctl_ack and refresh_req in the same cycle: finish the access, go to IDLE, then REFRESH.
  - Port priority applies only in IDLE.
- Spurious inputs: ctl_ack in IDLE or REFRESH is ignored; refresh_done outside REFRESH is ignored.
- Reset mid-operation: immediate return to reset values. The controller is also reset on RESET_n.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined: ports 0 and 1 alternate round-robin.
  - A last-owner flag records which port was granted last.
  - When both ports request in IDLE, the port that was not granted last wins.
  - Refresh still has top priority.
  - The starvation counter and MAX_WAIT are compiled out.
- Undefined: fixed priority with the starvation guard, as described above.

Decomposition:
- Shared package sdram_pkg holds:
  - arbiter state encodings.
  - grant codes GNT_NONE, GNT_P0, GNT_P1, GNT_REF.
  - the address width constant (26).
- One sub-module: sdram_arb_starve_ctr, the saturating wait counter. It is omitted under SDRAM_ARB_RR_EN.

Test Plan:
1. Single port 0 read:
   - Stimulus: req0 = 1, addr0 = 26'h0000123, rw0 = 1.
   - Response: ctl_req high 1 cycle later with ctl_addr = 26'h0000123 and grant = 01. Pulse ctl_ack 3 cycles later -> ack0 in the same cycle, ctl_req low next cycle.
2. Refresh priority:
   - Stimulus: refresh_req, req0 and req1 all asserted in IDLE.
   - Response: ctl_refresh = 1 and grant = 11. After refresh_done: GNT0, then GNT1.
3. Starvation, MAX_WAIT = 4:
   - Stimulus: req1 held; req0 re-asserted immediately after each ack0.
   - Response: GNT1 is taken once the counter reaches 4, even with req0 pending.
4. Abort:
   - Stimulus: req0 drops 1 cycle after grant.
   - Response: ctl_req held until ctl_ack, ack0 stays 0, then IDLE.
5. Reset mid-grant:
   - Stimulus: RESET_n low while in GNT1.
   - Response: all outputs return to reset values asynchronously, without waiting for a clock edge.
6. SDRAM_ARB_RR_EN defined:
   - Stimulus: req0 and req1 held continuously.
   - Response: grants alternate 01, 10, 01, 10.
